// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: start/spike request, layer ROM port and accumulator status bundle
interface layer_sequencer_if #(
  parameter int w_size      = 8,
  parameter int neurons_in  = 4,
  parameter int neurons_out = 2,
  parameter int acc_size    = 12
);
  logic                            start;
  logic                            clear_acc;
  logic [neurons_in-1:0]           spikes_in;
  logic [neurons_in-1:0]           rom_addr;
  logic [neurons_out*w_size-1:0]   rom_data;
  logic [neurons_out*acc_size-1:0] acc_out;
  logic                            busy;
  logic                            done;
  modport master (output start, clear_acc, spikes_in, rom_data, input rom_addr, acc_out, busy, done);
  modport slave  (input start, clear_acc, spikes_in, rom_data, output rom_addr, acc_out, busy, done);
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: scans set spikes lowest-first, adding one ROM word per spike into saturating accumulators
//   clk, rst_n : clock, async active-low reset
//   s (slave)  : start/clear_acc/spikes_in request, rom_addr/rom_data one-hot ROM port,
//                acc_out packed signed accumulators, busy (SCAN/DONE), done (1-cycle pulse)
module layer_sequencer #(
  parameter int w_size      = 8,
  parameter int neurons_in  = 4,
  parameter int neurons_out = 2,
  parameter int acc_size    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  layer_sequencer_if.slave  s
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t                                    state_q, state_d;
  logic [neurons_in-1:0]                     pend_q, pend_d, sel;
  logic [neurons_out-1:0][acc_size-1:0]      acc_q, acc_d, sat;
  // isolate lowest set pending bit
  assign sel = pend_q & (~pend_q + 1'b1);
  for (genvar j = 0; j < neurons_out; j++) begin : g_n
    logic [acc_size:0] sum;
    assign sum = {acc_q[j][acc_size-1], acc_q[j]} +
                 {{(acc_size+1-w_size){s.rom_data[(j+1)*w_size-1]}}, s.rom_data[j*w_size +: w_size]};
    // one guard bit: disagreement with the sign bit means overflow, clamp toward the guard's sign
    assign sat[j] = (sum[acc_size] != sum[acc_size-1]) ?
                    {sum[acc_size], {(acc_size-1){~sum[acc_size]}}} : sum[acc_size-1:0];
  end
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    acc_d   = acc_q;
    if (state_q == IDLE && s.start) begin
      pend_d  = s.spikes_in;
      acc_d   = s.clear_acc ? '0 : acc_q;
      state_d = (s.spikes_in != '0) ? SCAN : DONE;
    end else if (state_q == SCAN) begin
      pend_d  = pend_q & ~sel;
      acc_d   = sat;
      state_d = ((pend_q & ~sel) == '0) ? DONE : SCAN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
    end
  end
  assign s.rom_addr = (state_q == SCAN) ? sel : '0;
  assign s.acc_out  = acc_q;
  assign s.busy     = (state_q != IDLE);
  assign s.done     = (state_q == DONE);
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed + random spike vectors checked against a per-spike saturating-sum model
module tb_layer_sequencer;
  logic clk = 0;
  logic rst_n = 0;
  int   checks = 0;
  int   errors = 0;
  bit   ovr = 0;
  int   m0 = 0, m1 = 0;
  always #5 clk = ~clk;
  layer_sequencer_if #(.w_size(8), .neurons_in(4), .neurons_out(2), .acc_size(12)) bus ();
  layer_sequencer #(.w_size(8), .neurons_in(4), .neurons_out(2), .acc_size(12)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave));
  function automatic int w0(int i);
    return (ovr && i == 0) ? 127 : 10 * (i + 1);
  endfunction
  function automatic int w1(int i);
    return (ovr && i == 0) ? -128 : -(i + 1);
  endfunction
  always_comb begin
    bus.rom_data = '0;
    for (int i = 0; i < 4; i++)
      if (bus.rom_addr[i]) bus.rom_data = {8'(w1(i)), 8'(w0(i))};
  end
  function automatic int clamp(int v);
    return v > 2047 ? 2047 : (v < -2048 ? -2048 : v);
  endfunction
  function automatic void model(logic [3:0] sp, bit clr);
    if (clr) begin m0 = 0; m1 = 0; end
    for (int i = 0; i < 4; i++)
      if (sp[i]) begin m0 = clamp(m0 + w0(i)); m1 = clamp(m1 + w1(i)); end
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask
  task automatic chk_acc(string tag);
    chk({tag, "_acc0"}, $signed(bus.acc_out[11:0]), m0);
    chk({tag, "_acc1"}, $signed(bus.acc_out[23:12]), m1);
  endtask
  task automatic run(input logic [3:0] sp, input bit clr, input bit poke);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    bus.start = 1; bus.clear_acc = clr; bus.spikes_in = sp;
    @(negedge clk);
    bus.start = poke; bus.spikes_in = 4'($urandom); bus.clear_acc = 1'($urandom);
    model(sp, clr);
    for (int i = 0; i < 4; i++)
      if (sp[i]) begin
        chk("scan_addr", bus.rom_addr, 32'(1) << i);
        chk("scan_done", bus.done, 0);
        chk("scan_busy", bus.busy, 1);
        @(negedge clk);
        bus.start = 0;
      end
    bus.start = 0;
    chk("done_pulse", bus.done, 1);
    chk("done_addr", bus.rom_addr, 0);
    chk("done_busy", bus.busy, 1);
    chk_acc("done");
    @(negedge clk);
    chk("done_once", bus.done, 0);
    chk("back_idle", bus.busy, 0);
    chk("idle_addr", bus.rom_addr, 0);
  endtask
  initial begin
    bus.start = 0; bus.clear_acc = 0; bus.spikes_in = '0;
    #1;
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_acc", bus.acc_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    run(4'b1011, 1, 0);
    chk("r31_acc0", $signed(bus.acc_out[11:0]), 70);
    chk("r31_acc1", $signed(bus.acc_out[23:12]), -7);
    run(4'b1011, 0, 1);
    chk("r32_acc0", $signed(bus.acc_out[11:0]), 140);
    chk("r32_acc1", $signed(bus.acc_out[23:12]), -14);
    run(4'b0000, 1, 0);
    chk("r33_acc", bus.acc_out, 0);
    ovr = 1;
    for (int n = 0; n < 20; n++) run(4'b0001, n == 0, 0);
    chk("sat_acc0", $signed(bus.acc_out[11:0]), 2047);
    chk("sat_acc1", $signed(bus.acc_out[23:12]), -2048);
    ovr = 0;
    @(negedge clk);
    bus.start = 1; bus.clear_acc = 1; bus.spikes_in = 4'b1111;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_addr", bus.rom_addr, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_acc", bus.acc_out, 0);
    m0 = 0; m1 = 0;
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_no_done", bus.done, 0);
    end
    run(4'b0100, 0, 0);
    chk("r35_acc0", $signed(bus.acc_out[11:0]), 30);
    chk("r35_acc1", $signed(bus.acc_out[23:12]), -3);
    for (int n = 0; n < 12; n++)
      run(4'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
